mult_issue_scheduler: RTL and testbench

//  Sequences the register-file + multiplier datapath: accepts multiply commands (dst = src1*src2),

---
 rtl/mult_sched_pkg.sv | 24 ++
 rtl/mult_inflight_pipe.sv | 90 +++++++++
 rtl/mult_issue_scheduler.sv | 162 ++++++++++++++++
 tb/tb_mult_issue_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_sched_pkg.sv
// -----------------------------------------------------------------------------
// mult_sched_pkg
//   Shared types for the multiply issue scheduler:
//     state_e     - scheduler FSM states (idle / running / draining)
//     inflight_t  - one multiplier pipeline slot: valid flag + destination reg
//   REG_ADDR_WIDTH_DEF is the register address width carried by inflight_t;
//   the scheduler's REG_ADDR_WIDTH parameter defaults to it and must match it.
// -----------------------------------------------------------------------------
package mult_sched_pkg;

  localparam int REG_ADDR_WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic                          valid;
    logic [REG_ADDR_WIDTH_DEF-1:0] dst;
  } inflight_t;

endpackage

// File: rtl/mult_inflight_pipe.sv
// -----------------------------------------------------------------------------
// mult_inflight_pipe
//   Tracks every issued multiply through the fixed-latency multiplier and
//   keeps the per-register pending scoreboard.
//   Ports:
//     clk, rst      clock, synchronous active-high reset (drops all entries)
//     issue_valid   a command is issued this cycle
//     issue_dst     destination register of the issued command
//     wb_valid      the oldest entry leaves the multiplier this cycle
//     wb_dst        destination register of that entry
//     pend          one bit per register: a product for it is still in flight
//     empty         no entry valid anywhere in the pipe
//   Timing: an entry issued in cycle T sits in stage k during cycle T+1+k and
//   is reported on wb_* in cycle T+MULT_LAT. pend[dst] rises at T+1 and falls
//   at T+MULT_LAT+1.
// -----------------------------------------------------------------------------
module mult_inflight_pipe
  import mult_sched_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
  parameter int MULT_LAT       = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        issue_valid,
  input  logic [REG_ADDR_WIDTH-1:0]   issue_dst,
  output logic                        wb_valid,
  output logic [REG_ADDR_WIDTH-1:0]   wb_dst,
  output logic [(1<<REG_ADDR_WIDTH)-1:0] pend,
  output logic                        empty
);

  localparam int NUM_REGS = 1 << REG_ADDR_WIDTH;

  inflight_t              stage_reg [MULT_LAT];
  logic [MULT_LAT-1:0]    stage_valid;
  logic [NUM_REGS-1:0]    pend_reg;
  logic [NUM_REGS-1:0]    pend_next;

  // Shift register: stage 0 captures the issue, the last stage is the
  // write-back slot. Entries never stall, so the latency is exact.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MULT_LAT; i++) begin
        stage_reg[i] <= '0;
      end
    end else begin
      stage_reg[0].valid <= issue_valid;
      stage_reg[0].dst   <= REG_ADDR_WIDTH_DEF'(issue_dst);
      for (int i = 1; i < MULT_LAT; i++) begin
        stage_reg[i] <= stage_reg[i-1];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < MULT_LAT; gi++) begin : g_stage_valid
      assign stage_valid[gi] = stage_reg[gi].valid;
    end
  endgenerate

  assign wb_valid = stage_reg[MULT_LAT-1].valid;
  assign wb_dst   = REG_ADDR_WIDTH'(stage_reg[MULT_LAT-1].dst);
  assign empty    = ~|stage_valid;

  // Clear before set: the issue side never targets a register that is still
  // pending, so the order only matters for readability, but setting last
  // keeps a fresh issue authoritative.
  always_comb begin
    pend_next = pend_reg;
    if (wb_valid) begin
      pend_next[wb_dst] = 1'b0;
    end
    if (issue_valid) begin
      pend_next[issue_dst] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_reg <= '0;
    end else begin
      pend_reg <= pend_next;
    end
  end

  assign pend = pend_reg;

endmodule

// File: rtl/mult_issue_scheduler.sv
// -----------------------------------------------------------------------------
// mult_issue_scheduler
//   Sequences a register file + fixed-latency multiplier datapath.
//   Multiply commands (dst = src1 * src2) drive the register read ports in the
//   accept cycle; the product is written back MULT_LAT cycles later through the
//   single write port (w_sel=1). Host writes share that port and always lose
//   to a write-back. A per-register pending scoreboard blocks RAW/WAW hazards.
//   Ports:
//     clk, rst                       clock, synchronous active-high reset
//     cmd_valid/ready, cmd_dst/src1/src2   multiply command handshake
//     host_wr_valid/ready, host_wr_addr/data  host register write handshake
//     drain_req / drain_done         stop taking commands / pulse when empty
//     busy                           any multiply in flight
//     retire_cnt                     write-backs completed (wrapping)
//     r_valid1/2, r_addr1/2          register file read ports
//     w_valid, w_sel, w_addr, w_data register file write port
//                                    (w_sel=1 selects multiplier output)
// -----------------------------------------------------------------------------
module mult_issue_scheduler
  import mult_sched_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
  parameter int REG_DATA_WIDTH = 16,
  parameter int MULT_LAT       = 3,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [REG_ADDR_WIDTH-1:0] cmd_dst,
  input  logic [REG_ADDR_WIDTH-1:0] cmd_src1,
  input  logic [REG_ADDR_WIDTH-1:0] cmd_src2,
  input  logic                      host_wr_valid,
  output logic                      host_wr_ready,
  input  logic [REG_ADDR_WIDTH-1:0] host_wr_addr,
  input  logic [REG_DATA_WIDTH-1:0] host_wr_data,
  input  logic                      drain_req,
  output logic                      drain_done,
  output logic                      busy,
  output logic [CNT_WIDTH-1:0]      retire_cnt,
  output logic                      r_valid1,
  output logic [REG_ADDR_WIDTH-1:0] r_addr1,
  output logic                      r_valid2,
  output logic [REG_ADDR_WIDTH-1:0] r_addr2,
  output logic                      w_valid,
  output logic                      w_sel,
  output logic [REG_ADDR_WIDTH-1:0] w_addr,
  output logic [REG_DATA_WIDTH-1:0] w_data
);

  localparam int NUM_REGS = 1 << REG_ADDR_WIDTH;

  state_e                      state_reg;
  state_e                      state_next;
  logic                        cmd_accept;
  logic                        host_accept;
  logic                        wb_valid;
  logic [REG_ADDR_WIDTH-1:0]   wb_dst;
  logic [NUM_REGS-1:0]         pend;
  logic                        pipe_empty;
  logic [CNT_WIDTH-1:0]        retire_cnt_reg;

  mult_inflight_pipe #(
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
    .MULT_LAT       (MULT_LAT)
  ) u_pipe (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (cmd_accept),
    .issue_dst   (cmd_dst),
    .wb_valid    (wb_valid),
    .wb_dst      (wb_dst),
    .pend        (pend),
    .empty       (pipe_empty)
  );

  // Handshakes. Held low while reset is asserted so nothing is issued into a
  // pipe that is being cleared. Checking dst as well as both sources covers
  // WAW and the dst==src case with the same test.
  assign cmd_ready = !rst && (state_reg != S_DRAIN) &&
                     !pend[cmd_src1] && !pend[cmd_src2] && !pend[cmd_dst];
  assign host_wr_ready = !rst && !wb_valid && !pend[host_wr_addr];

  assign cmd_accept  = cmd_valid && cmd_ready;
  assign host_accept = host_wr_valid && host_wr_ready;

  // FSM. drain_req takes priority over a simultaneous accept; an op accepted
  // in that same cycle is simply part of what the drain waits for.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (drain_req) begin
          state_next = S_DRAIN;
        end else if (cmd_accept) begin
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (drain_req) begin
          state_next = S_DRAIN;
        end else if (pipe_empty && !cmd_accept) begin
          state_next = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (pipe_empty) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Pulses exactly once: the cycle DRAIN sees an empty pipe it also leaves.
  assign drain_done = (state_reg == S_DRAIN) && pipe_empty;
  assign busy       = !pipe_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt_reg <= '0;
    end else if (wb_valid) begin
      retire_cnt_reg <= retire_cnt_reg + CNT_WIDTH'(1);
    end
  end

  assign retire_cnt = retire_cnt_reg;

  // Read ports: operands are fetched in the accept cycle itself.
  assign r_valid1 = cmd_accept;
  assign r_valid2 = cmd_accept;
  assign r_addr1  = cmd_accept ? cmd_src1 : '0;
  assign r_addr2  = cmd_accept ? cmd_src2 : '0;

  // Write port: write-back has priority; host_accept is already false in a
  // write-back cycle, so the two never overlap.
  always_comb begin
    w_valid = 1'b0;
    w_sel   = 1'b0;
    w_addr  = '0;
    w_data  = '0;
    if (wb_valid) begin
      w_valid = 1'b1;
      w_sel   = 1'b1;
      w_addr  = wb_dst;
    end else if (host_accept) begin
      w_valid = 1'b1;
      w_addr  = host_wr_addr;
      w_data  = host_wr_data;
    end
  end

endmodule

// File: tb/tb_mult_issue_scheduler.sv
module tb_mult_issue_scheduler;

  localparam int RAW = 4;
  localparam int RDW = 16;
  localparam int LAT = 3;
  localparam int CW  = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic [RAW-1:0] cmd_dst = '0;
  logic [RAW-1:0] cmd_src1 = '0;
  logic [RAW-1:0] cmd_src2 = '0;
  logic           host_wr_valid = 1'b0;
  logic           host_wr_ready;
  logic [RAW-1:0] host_wr_addr = '0;
  logic [RDW-1:0] host_wr_data = '0;
  logic           drain_req = 1'b0;
  logic           drain_done;
  logic           busy;
  logic [CW-1:0]  retire_cnt;
  logic           r_valid1, r_valid2;
  logic [RAW-1:0] r_addr1, r_addr2;
  logic           w_valid, w_sel;
  logic [RAW-1:0] w_addr;
  logic [RDW-1:0] w_data;

  mult_issue_scheduler #(
    .REG_ADDR_WIDTH (RAW),
    .REG_DATA_WIDTH (RDW),
    .MULT_LAT       (LAT),
    .CNT_WIDTH      (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_dst       (cmd_dst),
    .cmd_src1      (cmd_src1),
    .cmd_src2      (cmd_src2),
    .host_wr_valid (host_wr_valid),
    .host_wr_ready (host_wr_ready),
    .host_wr_addr  (host_wr_addr),
    .host_wr_data  (host_wr_data),
    .drain_req     (drain_req),
    .drain_done    (drain_done),
    .busy          (busy),
    .retire_cnt    (retire_cnt),
    .r_valid1      (r_valid1),
    .r_addr1       (r_addr1),
    .r_valid2      (r_valid2),
    .r_addr2       (r_addr2),
    .w_valid       (w_valid),
    .w_sel         (w_sel),
    .w_addr        (w_addr),
    .w_data        (w_data)
  );

  always #5 clk = ~clk;

  // Cycle number: value k holds from the k-th rising edge to the next one.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file and multiplier that the scheduler sequences.
  logic [RDW-1:0] rf    [16];
  logic [RDW-1:0] mpipe [LAT];
  logic [RDW-1:0] mult_out;
  assign mult_out = mpipe[LAT-1];

  always @(posedge clk) begin
    if (w_valid) rf[w_addr] <= w_sel ? mult_out : w_data;
    mpipe[0] <= (r_valid1 && r_valid2) ? rf[r_addr1] * rf[r_addr2] : 16'hDEAD;
    for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
  end

  // Reference register contents and scoreboard of expected write-backs.
  logic [RDW-1:0] gold [16];
  typedef struct {
    int             cyc;
    logic [RAW-1:0] dst;
    logic [RDW-1:0] val;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;
  int   exp_retire = 0;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Write-back monitor: every w_sel=1 write must match the oldest expected one.
  always @(negedge clk) begin
    if (w_valid && w_sel) begin
      if (sb_q.size() == 0) begin
        check_eq("wb_unexpected", 32'(w_addr), 32'hFFFF_FFFF);
      end else begin
        mon_e = sb_q.pop_front();
        $display("wb    cyc=%0d addr=%0d data=%0d", cyc, w_addr, mult_out);
        check_eq("wb_cycle", 32'(cyc), 32'(mon_e.cyc));
        check_eq("wb_addr", 32'(w_addr), 32'(mon_e.dst));
        check_eq("wb_data", 32'(mult_out), 32'(mon_e.val));
        gold[mon_e.dst] = mon_e.val;
        exp_retire++;
      end
    end
  end

  task automatic wait_cyc(input int target);
    do @(negedge clk); while (cyc < target);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic issue(input logic [RAW-1:0] d, input logic [RAW-1:0] s1,
                       input logic [RAW-1:0] s2, output int acc);
    int n = 0;
    cmd_valid = 1'b1; cmd_dst = d; cmd_src1 = s1; cmd_src2 = s2;
    @(negedge clk);
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      check_eq("issue_timeout", 32'd0, 32'd1);
      acc = -1;
    end else begin
      acc = cyc;
      $display("issue cyc=%0d dst=%0d src1=%0d src2=%0d", cyc, d, s1, s2);
      check_eq("issue_rd", 32'({r_valid1, r_valid2, r_addr1, r_addr2}), 32'({2'b11, s1, s2}));
      sb_q.push_back('{cyc + LAT, d, gold[s1] * gold[s2]});
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic host_write(input logic [RAW-1:0] a, input logic [RDW-1:0] dv, output int acc);
    int n = 0;
    host_wr_valid = 1'b1; host_wr_addr = a; host_wr_data = dv;
    @(negedge clk);
    while (!host_wr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!host_wr_ready) begin
      check_eq("host_timeout", 32'd0, 32'd1);
      acc = -1;
    end else begin
      acc = cyc;
      $display("hostw cyc=%0d addr=%0d data=%0d", cyc, a, dv);
      check_eq("host_wport", 32'({w_valid, w_sel, w_addr, w_data}), 32'({2'b10, a, dv}));
      gold[a] = dv;
    end
    @(posedge clk);
    #1 host_wr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 40);
    if (busy) check_eq("idle_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t2, acc, a0, a1, dd_cnt, dd_cyc;
    int tp [4];
    logic [RAW-1:0] td [4];
    logic [RAW-1:0] ts1 [4];
    logic [RAW-1:0] ts2 [4];
    td  = '{4'd8, 4'd9, 4'd10, 4'd11};
    ts1 = '{4'd1, 4'd2, 4'd1,  4'd4};
    ts2 = '{4'd2, 4'd2, 4'd4,  4'd2};

    for (int i = 0; i < 16; i++) begin
      rf[i] = '0;
      gold[i] = '0;
    end
    for (int i = 0; i < LAT; i++) mpipe[i] = '0;

    // Reset state
    do_reset();
    @(negedge clk);
    check_eq("rst_flags", 32'({cmd_ready, host_wr_ready, r_valid1, r_valid2, w_valid, w_sel, busy, drain_done}),
             32'b1100_0000);
    check_eq("rst_addrs", 32'({r_addr1, r_addr2, w_addr}), 32'd0);
    check_eq("rst_wdata", 32'(w_data), 32'd0);
    check_eq("rst_retire", 32'(retire_cnt), 32'd0);
    @(posedge clk); #1;

    // Single op: r4 = r1 * r2 = 3 * 5
    host_write(4'd1, 16'd3, acc);
    host_write(4'd2, 16'd5, acc);
    issue(4'd4, 4'd1, 4'd2, t);
    wait_idle();
    check_eq("single_rf4", 32'(rf[4]), 32'd15);
    check_eq("single_retire", 32'(retire_cnt), 32'd1);

    // RAW hazard: dependent command waits until T+4
    issue(4'd4, 4'd1, 4'd2, t);
    issue(4'd5, 4'd4, 4'd1, t2);
    check_eq("raw_accept_cyc", 32'(t2), 32'(t + 4));
    wait_idle();
    check_eq("raw_rf5", 32'(rf[5]), 32'd45);

    // Write-port conflict: host write during write-back waits one cycle
    issue(4'd6, 4'd1, 4'd2, t);
    @(posedge clk); #1;
    @(posedge clk); #1;
    host_write(4'd7, 16'h1234, acc);
    check_eq("conflict_host_cyc", 32'(acc), 32'(t + 4));
    wait_idle();
    check_eq("conflict_rf7", 32'(rf[7]), 32'h1234);
    check_eq("conflict_rf6", 32'(rf[6]), 32'd15);

    // Throughput: four independent commands back to back
    for (int i = 0; i < 4; i++) issue(td[i], ts1[i], ts2[i], tp[i]);
    for (int i = 1; i < 4; i++) check_eq("tput_accept_cyc", 32'(tp[i]), 32'(tp[0] + i));
    wait_cyc(tp[0] + 6);
    check_eq("tput_busy_last_wb", 32'(busy), 32'd1);
    wait_cyc(tp[0] + 7);
    check_eq("tput_busy_fall", 32'(busy), 32'd0);
    check_eq("tput_retire", 32'(retire_cnt), 32'(exp_retire));
    @(posedge clk); #1;

    // Drain with two ops in flight
    issue(4'd12, 4'd1, 4'd2, a0);
    issue(4'd13, 4'd2, 4'd4, a1);
    drain_req = 1'b1;
    @(posedge clk); #1;
    drain_req = 1'b0;
    cmd_dst = 4'd15; cmd_src1 = 4'd1; cmd_src2 = 4'd1;
    dd_cnt = 0; dd_cyc = -1;
    for (int k = a0 + 3; k <= a0 + 10; k++) begin
      wait_cyc(k);
      if (k == a0 + 3 || k == a0 + 4) check_eq("drain_cmd_ready", 32'(cmd_ready), 32'd0);
      if (k == a0 + 6) check_eq("drain_idle_ready", 32'(cmd_ready), 32'd1);
      if (drain_done) begin
        dd_cnt++;
        dd_cyc = k;
      end
    end
    check_eq("drain_pulses", 32'(dd_cnt), 32'd1);
    check_eq("drain_done_cyc", 32'(dd_cyc), 32'(a0 + 5));
    @(posedge clk); #1;

    // Drain requested while idle: pulse on the next cycle
    drain_req = 1'b1;
    @(negedge clk);
    check_eq("idle_drain_pre", 32'(drain_done), 32'd0);
    @(posedge clk); #1;
    drain_req = 1'b0;
    @(negedge clk);
    check_eq("idle_drain_pulse", 32'(drain_done), 32'd1);
    @(negedge clk);
    check_eq("idle_drain_post", 32'(drain_done), 32'd0);
    @(posedge clk); #1;

    // Reset one cycle after issue: the op is dropped
    issue(4'd14, 4'd1, 4'd2, t);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb_q.delete();
    exp_retire = 0;
    cmd_dst = 4'd14; cmd_src1 = 4'd1; cmd_src2 = 4'd2;
    @(negedge clk);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_retire", 32'(retire_cnt), 32'd0);
    check_eq("midrst_pend_clear", 32'(cmd_ready), 32'd1);
    wait_cyc(t + 3);
    check_eq("midrst_no_wb", 32'(w_valid), 32'd0);
    wait_cyc(t + 6);
    check_eq("midrst_retire_late", 32'(retire_cnt), 32'd0);

    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
